hazard_unit_mc: RTL and testbench

Parametrised hazard unit for the 5-stage pipeline. It extends the single-cycle forwarding and load-use logic with three additions:
- an FSM and down-counter that stall F/D/E while a multi-cycle execute op (mul/div) occupies E;
- RegWrite/x0-qualified load-use detection;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives its stall, flush and forward-select controls.

---
 rtl/hazard_unit_mc.sv | 108 ++++++++++
 tb/tb_hazard_unit_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall, multi-cycle
// execute stall FSM and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic [REG_ADDR_W-1:0] i_Rs1D,
    input  logic [REG_ADDR_W-1:0] i_Rs2D,
    input  logic [REG_ADDR_W-1:0] i_Rs1E,
    input  logic [REG_ADDR_W-1:0] i_Rs2E,
    input  logic [REG_ADDR_W-1:0] i_RdE,
    input  logic [REG_ADDR_W-1:0] i_RdM,
    input  logic [REG_ADDR_W-1:0] i_RdW,
    input  logic                  i_RegWriteE,
    input  logic                  i_RegWriteM,
    input  logic                  i_RegWriteW,
    input  logic                  i_ResultSrcE_0,
    input  logic                  i_MultiCycleE,
    input  logic                  i_PCSrcE,
    input  logic                  i_CntClr,
    output logic                  o_StallF,
    output logic                  o_StallD,
    output logic                  o_StallE,
    output logic                  o_FlushD,
    output logic                  o_FlushE,
    output logic                  o_FlushM,
    output logic [1:0]            o_ForwardAE,
    output logic [1:0]            o_ForwardBE,
    output logic                  o_McBusy,
    output logic [CNT_W-1:0]      o_StallCnt
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // First E cycle is spent in IDLE, last with the counter at zero.
    localparam logic [7:0] LP_LOAD = 8'(MC_LATENCY - 2);

    state_t           r_State;
    logic [7:0]       r_McCnt;
    logic [CNT_W-1:0] r_StallCnt;
    logic             w_LwStall;
    logic             w_McStall;

    assign o_ForwardAE = (i_Rs1E != '0 && i_Rs1E == i_RdM && i_RegWriteM) ? 2'b10 :
                         (i_Rs1E != '0 && i_Rs1E == i_RdW && i_RegWriteW) ? 2'b01 : 2'b00;
    assign o_ForwardBE = (i_Rs2E != '0 && i_Rs2E == i_RdM && i_RegWriteM) ? 2'b10 :
                         (i_Rs2E != '0 && i_Rs2E == i_RdW && i_RegWriteW) ? 2'b01 : 2'b00;

    assign w_LwStall = i_ResultSrcE_0 & i_RegWriteE & (i_RdE != '0) &
                       ((i_Rs1D == i_RdE) | (i_Rs2D == i_RdE));
    assign w_McStall = ((r_State == S_IDLE) & i_MultiCycleE & ~i_PCSrcE) |
                       ((r_State == S_BUSY) & (r_McCnt != 8'd0));

    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushM = 1'b0;
        if (i_PCSrcE) begin
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
        end else if (w_McStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_FlushM = 1'b1;
        end else if (w_LwStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State <= S_IDLE;
            r_McCnt <= 8'd0;
        end else if (i_PCSrcE) begin
            r_State <= S_IDLE;
            r_McCnt <= 8'd0;
        end else begin
            case (r_State)
                S_IDLE: if (i_MultiCycleE) begin
                    r_State <= S_BUSY;
                    r_McCnt <= LP_LOAD;
                end
                S_BUSY: if (r_McCnt == 8'd0) r_State <= S_IDLE;
                        else                 r_McCnt <= r_McCnt - 8'd1;
                default: r_State <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)                            r_StallCnt <= '0;
        else if (i_CntClr)                       r_StallCnt <= '0;
        else if (o_StallF && r_StallCnt != '1)   r_StallCnt <= r_StallCnt + CNT_W'(1);
    end

    assign o_McBusy   = (r_State == S_BUSY);
    assign o_StallCnt = r_StallCnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (latency 4 / 16-bit count, latency 2 /
// 3-bit count) checked against a remaining-cycles reference model.
module tb_hazard_unit_mc;

    logic       i_Clk, i_Rst_n;
    logic [4:0] i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW;
    logic       i_RegWriteE, i_RegWriteM, i_RegWriteW, i_ResultSrcE_0;
    logic       i_MultiCycleE, i_PCSrcE, i_CntClr;

    logic        o1_StallF, o1_StallD, o1_StallE, o1_FlushD, o1_FlushE, o1_FlushM, o1_McBusy;
    logic [1:0]  o1_FwdA, o1_FwdB;
    logic [15:0] o1_StallCnt;
    logic        o2_StallF, o2_StallD, o2_StallE, o2_FlushD, o2_FlushE, o2_FlushM, o2_McBusy;
    logic [1:0]  o2_FwdA, o2_FwdB;
    logic [2:0]  o2_StallCnt;

    hazard_unit_mc #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(16)) u_dut1 (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D),
        .i_Rs1E(i_Rs1E), .i_Rs2E(i_Rs2E), .i_RdE(i_RdE), .i_RdM(i_RdM), .i_RdW(i_RdW),
        .i_RegWriteE(i_RegWriteE), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
        .i_ResultSrcE_0(i_ResultSrcE_0), .i_MultiCycleE(i_MultiCycleE), .i_PCSrcE(i_PCSrcE),
        .i_CntClr(i_CntClr), .o_StallF(o1_StallF), .o_StallD(o1_StallD), .o_StallE(o1_StallE),
        .o_FlushD(o1_FlushD), .o_FlushE(o1_FlushE), .o_FlushM(o1_FlushM),
        .o_ForwardAE(o1_FwdA), .o_ForwardBE(o1_FwdB), .o_McBusy(o1_McBusy),
        .o_StallCnt(o1_StallCnt));

    hazard_unit_mc #(.REG_ADDR_W(5), .MC_LATENCY(2), .CNT_W(3)) u_dut2 (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Rs1D(i_Rs1D), .i_Rs2D(i_Rs2D),
        .i_Rs1E(i_Rs1E), .i_Rs2E(i_Rs2E), .i_RdE(i_RdE), .i_RdM(i_RdM), .i_RdW(i_RdW),
        .i_RegWriteE(i_RegWriteE), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
        .i_ResultSrcE_0(i_ResultSrcE_0), .i_MultiCycleE(i_MultiCycleE), .i_PCSrcE(i_PCSrcE),
        .i_CntClr(i_CntClr), .o_StallF(o2_StallF), .o_StallD(o2_StallD), .o_StallE(o2_StallE),
        .o_FlushD(o2_FlushD), .o_FlushE(o2_FlushE), .o_FlushM(o2_FlushM),
        .o_ForwardAE(o2_FwdA), .o_ForwardBE(o2_FwdB), .o_McBusy(o2_McBusy),
        .o_StallCnt(o2_StallCnt));

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // ctl vector: {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA[1:0],FwdB[1:0],McBusy}
    wire [10:0] w_act1 = {o1_StallF, o1_StallD, o1_StallE, o1_FlushD, o1_FlushE, o1_FlushM,
                          o1_FwdA, o1_FwdB, o1_McBusy};
    wire [10:0] w_act2 = {o2_StallF, o2_StallD, o2_StallE, o2_FlushD, o2_FlushE, o2_FlushM,
                          o2_FwdA, o2_FwdB, o2_McBusy};

    int checks = 0;
    int failures = 0;
    int left1 = 0, left2 = 0;  // E cycles still owed to the current multi-cycle op
    int cnt1 = 0, cnt2 = 0;
    logic [10:0] s1, s2;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww, ld, pc;
        logic [1:0] fa, fb;
        logic [5:0] sf;  // {StallF,StallD,StallE,FlushD,FlushE,FlushM}
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 0 && rs == i_RdM && i_RegWriteM) return 2'b10;
        if (rs != 0 && rs == i_RdW && i_RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    // One model cycle: whether the op in E stalls, and cycles left afterwards.
    task automatic mstep(input int left, input int lat, output bit mc, output int left_n);
        if (left == 0) begin
            mc     = i_MultiCycleE && !i_PCSrcE;
            left_n = mc ? lat - 1 : 0;
        end else begin
            mc     = left > 1;
            left_n = left - 1;
        end
        if (i_PCSrcE) left_n = 0;
    endtask

    function automatic logic [10:0] exp_ctl(input bit mc, input bit busy);
        bit lw;
        logic [5:0] sf;
        lw = i_ResultSrcE_0 && i_RegWriteE && i_RdE != 0 && (i_Rs1D == i_RdE || i_Rs2D == i_RdE);
        if (i_PCSrcE)  sf = 6'b000110;
        else if (mc)   sf = 6'b111001;
        else if (lw)   sf = 6'b110010;
        else           sf = 6'b000000;
        return {sf, fwd(i_Rs1E), fwd(i_Rs2E), busy};
    endfunction

    function automatic int nextcnt(input int c, input bit st, input int max);
        if (i_CntClr) return 0;
        if (st && c < max) return c + 1;
        return c;
    endfunction

    // Inputs are set before the call; checks at negedge, model advances at posedge.
    task automatic cyc();
        bit mc1, mc2;
        int n1, n2;
        logic [10:0] e1, e2;
        @(negedge i_Clk);
        mstep(left1, 4, mc1, n1);
        mstep(left2, 2, mc2, n2);
        e1 = exp_ctl(mc1, left1 != 0);
        e2 = exp_ctl(mc2, left2 != 0);
        chk("ctl1", 32'(w_act1), 32'(e1));
        chk("ctl2", 32'(w_act2), 32'(e2));
        chk("cnt1", 32'(o1_StallCnt), cnt1);
        chk("cnt2", 32'(o2_StallCnt), cnt2);
        s1 = w_act1;
        s2 = w_act2;
        left1 = n1;
        left2 = n2;
        cnt1 = nextcnt(cnt1, e1[10], 65535);
        cnt2 = nextcnt(cnt2, e2[10], 7);
        @(posedge i_Clk);
        #1;
    endtask

    task automatic clr_in();
        {i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW} = '0;
        {i_RegWriteE, i_RegWriteM, i_RegWriteW, i_ResultSrcE_0} = '0;
        {i_MultiCycleE, i_PCSrcE, i_CntClr} = '0;
    endtask

    initial begin
        logic [3:0] ps1, pb1, ps2, pb2;
        int base;
        clr_in();
        i_Rst_n = 1'b0;
        #12;
        chk("rst_busy1", 32'(o1_McBusy), 0);
        chk("rst_busy2", 32'(o2_McBusy), 0);
        chk("rst_cnt1", 32'(o1_StallCnt), 0);
        chk("rst_cnt2", 32'(o2_StallCnt), 0);
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        vt[0] = '{rs1e:5, rdm:5, rwm:1, rdw:5, rww:1, fa:2'b10, default:0};
        vt[1] = '{rs1e:5, rdm:5, rwm:0, rdw:5, rww:1, fa:2'b01, default:0};
        vt[2] = '{rs1e:0, rdm:0, rwm:1, rdw:0, rww:1, default:0};
        vt[3] = '{rs1e:4, rs2e:3, rdm:4, rwm:1, rdw:3, rww:1, fa:2'b10, fb:2'b01, default:0};
        vt[4] = '{rde:7, rwe:1, ld:1, rs2d:7, sf:6'b110010, default:0};
        vt[5] = '{rde:7, rwe:1, ld:0, rs2d:7, default:0};
        vt[6] = '{rde:0, rwe:1, ld:1, default:0};
        vt[7] = '{rde:7, rwe:0, ld:1, rs1d:7, default:0};
        vt[8] = '{rde:7, rwe:1, ld:1, rs1d:7, pc:1, sf:6'b000110, default:0};
        for (int i = 0; i < 9; i++) begin
            clr_in();
            i_Rs1D = vt[i].rs1d; i_Rs2D = vt[i].rs2d; i_Rs1E = vt[i].rs1e; i_Rs2E = vt[i].rs2e;
            i_RdE = vt[i].rde; i_RdM = vt[i].rdm; i_RdW = vt[i].rdw;
            i_RegWriteE = vt[i].rwe; i_RegWriteM = vt[i].rwm; i_RegWriteW = vt[i].rww;
            i_ResultSrcE_0 = vt[i].ld; i_PCSrcE = vt[i].pc;
            cyc();
            chk("vec_ctl", 32'(s1[10:5]), 32'(vt[i].sf));
            chk("vec_fwdA", 32'(s1[4:3]), 32'(vt[i].fa));
            chk("vec_fwdB", 32'(s1[2:1]), 32'(vt[i].fb));
        end

        // Latency-4 op on dut1; the same 4 cycles are two back-to-back ops on dut2.
        clr_in();
        base = cnt1;
        i_MultiCycleE = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            ps1 = {ps1[2:0], s1[10]}; pb1 = {pb1[2:0], s1[0]};
            ps2 = {ps2[2:0], s2[10]}; pb2 = {pb2[2:0], s2[0]};
        end
        chk("mc4_stall", 32'(ps1), 32'hE);
        chk("mc4_busy", 32'(pb1), 32'h7);
        chk("mc2_stall", 32'(ps2), 32'hA);
        chk("mc2_busy", 32'(pb2), 32'h5);
        chk("mc4_cnt", 32'(o1_StallCnt), base + 3);

        // Taken branch while dut1 is BUSY with counter 2.
        clr_in();
        i_MultiCycleE = 1'b1;
        cyc();
        i_PCSrcE = 1'b1;
        cyc();
        chk("br_ctl", 32'(s1[10:5]), 32'h06);
        clr_in();
        cyc();
        chk("br_idle", 32'(s1[0]), 0);
        chk("br_nostall", 32'(s1[10]), 0);

        // Saturation on the 3-bit counter.
        clr_in();
        i_CntClr = 1'b1;
        cyc();
        i_CntClr = 1'b0;
        i_ResultSrcE_0 = 1'b1; i_RegWriteE = 1'b1; i_RdE = 5'd7; i_Rs1D = 5'd7;
        for (int c = 0; c < 6; c++) cyc();
        chk("sat_pre", 32'(o2_StallCnt), 6);
        for (int c = 0; c < 3; c++) cyc();
        chk("sat_hold", 32'(o2_StallCnt), 7);
        clr_in();
        i_CntClr = 1'b1;
        cyc();
        chk("sat_clr", 32'(o2_StallCnt), 0);

        // Async reset mid-BUSY.
        clr_in();
        i_MultiCycleE = 1'b1;
        cyc();
        i_MultiCycleE = 1'b0;
        #2 i_Rst_n = 1'b0;
        #1;
        chk("arst_busy1", 32'(o1_McBusy), 0);
        chk("arst_cnt1", 32'(o1_StallCnt), 0);
        left1 = 0; left2 = 0; cnt1 = 0; cnt2 = 0;
        #2 i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("arst_nostall", 32'(s1[10]), 0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            i_Rs1D = 5'($urandom_range(0, 3)); i_Rs2D = 5'($urandom_range(0, 3));
            i_Rs1E = 5'($urandom_range(0, 3)); i_Rs2E = 5'($urandom_range(0, 3));
            i_RdE = 5'($urandom_range(0, 3));  i_RdM = 5'($urandom_range(0, 3));
            i_RdW = 5'($urandom_range(0, 3));
            i_RegWriteE = 1'($urandom); i_RegWriteM = 1'($urandom); i_RegWriteW = 1'($urandom);
            i_ResultSrcE_0 = ($urandom_range(0, 9) < 3);
            i_MultiCycleE  = ($urandom_range(0, 3) == 0);
            i_PCSrcE       = ($urandom_range(0, 24) < 2);
            i_CntClr       = ($urandom_range(0, 32) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
